// File: rtl/mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_arbiter
// Description : Shares one single-port no-change RAM between a CPU port and
//               a background dump engine. The CPU port always wins and sees
//               no wait states. The dump engine streams a window of words
//               (base, len) out through a valid/ready interface and takes RAM
//               cycles only when the CPU is idle. Addresses wrap modulo depth.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_arbiter #(
    parameter int RAM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    // CPU port: absolute priority, read latency of one cycle
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [RAM_WIDTH-1:0]  i_cpu_wdata,
    output logic                  o_cpu_gnt,
    output logic [RAM_WIDTH-1:0]  o_cpu_rdata,
    output logic                  o_cpu_rvalid,

    // Dump request: len is a word count, so it is one bit wider than an address
    input  logic                  i_dump_start,
    input  logic [ADDR_WIDTH-1:0] i_dump_base,
    input  logic [ADDR_WIDTH:0]   i_dump_len,

    // Dump stream
    output logic [RAM_WIDTH-1:0]  o_dump_data,
    output logic                  o_dump_valid,
    input  logic                  i_dump_ready,
    output logic                  o_dump_busy,
    output logic                  o_dump_done,

    // RAM port
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [RAM_WIDTH-1:0]  o_ram_data,
    output logic                  o_ram_we,
    input  logic [RAM_WIDTH-1:0]  i_ram_data
);

    // ------------------------------------------------------------------------
    // Dump state encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE    = 3'd0;  // waiting for a start pulse
    localparam logic [2:0] c_ST_ISSUE   = 3'd1;  // present dump address when CPU is idle
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;  // RAM output now holds the dump word
    localparam logic [2:0] c_ST_HOLD    = 3'd3;  // word offered downstream
    localparam logic [2:0] c_ST_DONE    = 3'd4;  // one-cycle completion pulse

    localparam logic [ADDR_WIDTH:0] c_INDEX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_index;
    logic [RAM_WIDTH-1:0]  r_dump_data;
    logic                  r_cpu_rvalid;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    logic [ADDR_WIDTH-1:0] w_dump_addr;
    logic [ADDR_WIDTH:0]   w_index_inc;
    logic                  w_last_word;
    logic                  w_start_ok;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_ram_addr;

    // Same-width addition drops the carry, which gives the modulo-depth wrap.
    assign w_dump_addr = r_base + r_index[ADDR_WIDTH-1:0];
    assign w_index_inc = r_index + c_INDEX_ONE;
    assign w_last_word = (w_index_inc == r_len);
    assign w_start_ok  = (r_state == c_ST_IDLE) && i_dump_start;
    assign w_accept    = (r_state == c_ST_HOLD) && i_dump_ready;

    // ------------------------------------------------------------------------
    // RAM port mux. The CPU owns the port whenever it asks; otherwise the dump
    // address is shown only while issuing, and the address is parked at its
    // last value the rest of the time so the RAM input does not toggle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ram_addr = r_addr_hold;
        if (i_cpu_req) begin
            w_ram_addr = i_cpu_addr;
        end else if (r_state == c_ST_ISSUE) begin
            w_ram_addr = w_dump_addr;
        end
    end

    assign o_ram_addr  = w_ram_addr;
    assign o_ram_data  = i_cpu_wdata;
    assign o_ram_we    = i_cpu_req & i_cpu_we;

    // CPU grant and read data are pass-through so they stay live during reset.
    assign o_cpu_gnt   = i_cpu_req;
    assign o_cpu_rdata = i_ram_data;
    assign o_cpu_rvalid = r_cpu_rvalid;

    // Remember the last address driven to the RAM so idle cycles can hold it.
    always_ff @(posedge i_clk) begin
        if (i_reset && !i_cpu_req) begin
            r_addr_hold <= '0;
        end else begin
            r_addr_hold <= w_ram_addr;
        end
    end

    // CPU read-valid: a read issued this cycle returns data next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= i_cpu_req & ~i_cpu_we;
        end
    end

    // ------------------------------------------------------------------------
    // Dump state machine
    // ------------------------------------------------------------------------

    // Next-state decode; a stolen ISSUE cycle simply retries the same word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_dump_start) begin
                    w_state_nxt = (i_dump_len == '0) ? c_ST_DONE : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (!i_cpu_req) begin
                    w_state_nxt = c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                w_state_nxt = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (i_dump_ready) begin
                    w_state_nxt = w_last_word ? c_ST_DONE : c_ST_ISSUE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State, request latch, word index and the captured dump word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= c_ST_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_index     <= '0;
            r_dump_data <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_ok) begin
                r_base  <= i_dump_base;
                r_len   <= i_dump_len;
                r_index <= '0;
            end

            if (w_accept) begin
                r_index <= w_index_inc;
            end

            // The no-change RAM keeps the dump word on its output even if the
            // CPU writes in this cycle, and a CPU read only changes it at the
            // coming edge, so capturing here is always safe.
            if (r_state == c_ST_CAPTURE) begin
                r_dump_data <= i_ram_data;
            end
        end
    end

    // Status outputs are pure state decodes, so they clear with the state.
    assign o_dump_data  = r_dump_data;
    assign o_dump_valid = (r_state == c_ST_HOLD);
    assign o_dump_done  = (r_state == c_ST_DONE);
    assign o_dump_busy  = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_data_arbiter
// Description : Self-checking bench for mem_data_arbiter. A behavioural
//               no-change RAM sits on the RAM port; a shadow array tracks the
//               bench's own writes and supplies every expected word. Dump
//               timing is predicted from word count, stolen cycles and
//               backpressure cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_data_arbiter;

    localparam int RW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [RW-1:0] cpu_wdata, cpu_rdata;
    logic          dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [AW-1:0] dump_base;
    logic [AW:0]   dump_len;
    logic [RW-1:0] dump_data;
    logic [AW-1:0] ram_addr;
    logic [RW-1:0] ram_wdata, ram_q;
    logic          ram_we;

    logic [RW-1:0] ram_mem [DEPTH];
    logic [RW-1:0] ref_mem [DEPTH];

    int vectors = 0;
    int errors  = 0;

    mem_data_arbiter #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .i_dump_start (dump_start),
        .i_dump_base  (dump_base),
        .i_dump_len   (dump_len),
        .o_dump_data  (dump_data),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done),
        .o_ram_addr   (ram_addr),
        .o_ram_data   (ram_wdata),
        .o_ram_we     (ram_we),
        .i_ram_data   (ram_q)
    );

    // Single-port no-change RAM: registered read, output held on writes.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_q <= ram_mem[ram_addr];
    end

    // Results of the most recent dump run
    logic [RW-1:0] obs_data[$];
    int            obs_cyc[$];
    logic [RW-1:0] cpu_obs[$];
    int            done_cnt, done_cyc;
    bit            unstable, busy_after, timed_out;

    // Drive one dump and record the stream; cycle 1 is the first cycle after
    // the start pulse is sampled.
    task automatic run_dump(input int base, input int len, input int steal_at, input int steal_n,
                            input int steal_addr, input int bp_word, input int bp_n,
                            input int restart_at);
        int cyc, bp_cnt, tmp;
        logic [RW-1:0] held;
        bit rdy;
        obs_data.delete(); obs_cyc.delete(); cpu_obs.delete();
        done_cnt = 0; done_cyc = -1; unstable = 0; busy_after = 1'b1; timed_out = 0;
        bp_cnt = 0; held = '0;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; dump_ready = 1'b1;
        dump_start = 1'b1; dump_base = base[AW-1:0]; dump_len = len[AW:0];
        @(posedge clk); #1;
        dump_start = 1'b0;
        cyc = 1;
        forever begin
            cpu_req  = (cyc >= steal_at) && (cyc < steal_at + steal_n);
            cpu_we   = 1'b0;
            cpu_addr = steal_addr[AW-1:0];
            dump_start = (cyc == restart_at);
            tmp = base + 37;
            dump_base = tmp[AW-1:0];
            tmp = len + 2;
            dump_len = tmp[AW:0];
            rdy = !((obs_data.size() == bp_word) && (bp_cnt < bp_n));
            dump_ready = rdy;
            @(negedge clk);
            if (dump_valid) begin
                if (rdy) begin
                    if (bp_cnt > 0 && obs_data.size() == bp_word && dump_data !== held) unstable = 1;
                    obs_data.push_back(dump_data);
                    obs_cyc.push_back(cyc);
                end else begin
                    if (bp_cnt == 0) held = dump_data;
                    else if (dump_data !== held) unstable = 1;
                    bp_cnt++;
                end
            end
            if (cpu_rvalid) cpu_obs.push_back(cpu_rdata);
            if (dump_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = dump_busy;
                break;
            end
            if (cyc > 20000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cpu_req = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    endtask

    // One CPU write cycle; request stays up until the next operation replaces it.
    task automatic cpu_write(input int addr, input logic [RW-1:0] data, output bit gnt, output bit hit);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr[AW-1:0]; cpu_wdata = data;
        @(negedge clk);
        gnt = cpu_gnt;
        hit = ram_we && (ram_addr == addr[AW-1:0]) && (ram_wdata == data);
        ref_mem[addr] = data;
    endtask

    // One CPU read cycle followed by an idle cycle that returns the data.
    task automatic cpu_read(input int addr, output bit gnt, output bit rv_during,
                            output bit rv_after, output logic [RW-1:0] rdata);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr[AW-1:0];
        @(negedge clk);
        gnt = cpu_gnt; rv_during = cpu_rvalid;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        rv_after = cpu_rvalid; rdata = cpu_rdata;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd100; cpu_wdata = 16'h1234;
        dump_start = 1'b1; dump_base = 10'd3; dump_len = 11'd2;
        @(negedge clk);
        ref_mem[100] = 16'h1234;
        vectors++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd100 || ram_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL reset_cpu_path: gnt=%b we=%b addr=%0d data=%h, required 1 1 100 1234",
                     cpu_gnt, ram_we, ram_addr, ram_wdata);
        end
        vectors++;
        if ({dump_busy, dump_valid, dump_done, cpu_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: busy/valid/done/rvalid=%b, required 0000",
                     {dump_busy, dump_valid, dump_done, cpu_rvalid});
        end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd7;
        @(negedge clk);
        vectors++;
        if (dump_busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd7) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b we=%b addr=%0d, required 0 0 7",
                     dump_busy, ram_we, ram_addr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dump_start = 1'b0; reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cpu_rvalid !== 1'b0 || dump_data !== '0) begin
            errors++;
            $display("FAIL reset_rvalid_data: rvalid=%b dump_data=%h, required 0 0000", cpu_rvalid, dump_data);
        end
    endtask

    task automatic test_plain_dump();
        run_dump(0, 3, 1, 0, 0, -1, 0, -1);
        vectors++;
        if (timed_out || obs_data.size() != 3) begin
            errors++;
            $display("FAIL plain_count: words=%0d timeout=%0d, required 3 0", obs_data.size(), timed_out);
        end
        for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
            vectors++;
            if (obs_data[k] !== ref_mem[k] || obs_cyc[k] != 3 * (k + 1)) begin
                errors++;
                $display("FAIL plain_word%0d: data=%h cyc=%0d, required %h cyc %0d",
                         k, obs_data[k], obs_cyc[k], ref_mem[k], 3 * (k + 1));
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != 10 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL plain_done: count=%0d cyc=%0d busy_after=%b, required 1 10 0",
                     done_cnt, done_cyc, busy_after);
        end
    endtask

    task automatic test_cpu_rw();
        bit g, h, rvd, rva;
        logic [RW-1:0] rd, d;
        int a;
        cpu_write(5, 16'hBEEF, g, h);
        vectors++;
        if (g !== 1'b1 || h !== 1'b1) begin
            errors++;
            $display("FAIL cpu_write_beef: gnt=%b ram_hit=%b, required 1 1", g, h);
        end
        cpu_read(5, g, rvd, rva, rd);
        vectors++;
        if (g !== 1'b1 || rvd !== 1'b0 || rva !== 1'b1 || rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL cpu_read_beef: gnt=%b rv_during=%b rv_after=%b data=%h, required 1 0 1 beef",
                     g, rvd, rva, rd);
        end
        cpu_read(100, g, rvd, rva, rd);
        vectors++;
        if (rva !== 1'b1 || rd !== 16'h1234) begin
            errors++;
            $display("FAIL cpu_read_reset_write: rvalid=%b data=%h, required 1 1234", rva, rd);
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(DEPTH - 1, 3);
            d = RW'($urandom);
            cpu_write(a, d, g, h);
            a = $urandom_range(DEPTH - 1, 0);
            cpu_read(a, g, rvd, rva, rd);
            vectors++;
            if (rva !== 1'b1 || rd !== ref_mem[a] || g !== 1'b1) begin
                errors++;
                $display("FAIL cpu_rand%0d: addr=%0d rvalid=%b data=%h, required 1 %h",
                         i, a, rva, rd, ref_mem[a]);
            end
        end
    endtask

    task automatic test_contention();
        run_dump(40, 3, 1, 4, 5, -1, 0, -1);
        vectors++;
        if (timed_out || obs_data.size() != 3 || cpu_obs.size() != 4) begin
            errors++;
            $display("FAIL contention_count: words=%0d cpu_reads=%0d, required 3 4",
                     obs_data.size(), cpu_obs.size());
        end
        for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
            vectors++;
            if (obs_data[k] !== ref_mem[40 + k] || obs_cyc[k] != 3 * (k + 1) + 4) begin
                errors++;
                $display("FAIL contention_word%0d: data=%h cyc=%0d, required %h cyc %0d",
                         k, obs_data[k], obs_cyc[k], ref_mem[40 + k], 3 * (k + 1) + 4);
            end
        end
        for (int k = 0; k < cpu_obs.size(); k++) begin
            vectors++;
            if (cpu_obs[k] !== ref_mem[5]) begin
                errors++;
                $display("FAIL contention_cpu%0d: data=%h, required %h", k, cpu_obs[k], ref_mem[5]);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != 14) begin
            errors++;
            $display("FAIL contention_done: count=%0d cyc=%0d, required 1 14", done_cnt, done_cyc);
        end
    endtask

    task automatic test_wrap_backpressure();
        run_dump(1022, 4, 1, 0, 0, 2, 5, -1);
        vectors++;
        if (timed_out || obs_data.size() != 4 || unstable) begin
            errors++;
            $display("FAIL wrap_count: words=%0d unstable=%0d, required 4 0", obs_data.size(), unstable);
        end
        for (int k = 0; k < 4 && k < obs_data.size(); k++) begin
            vectors++;
            if (obs_data[k] !== ref_mem[(1022 + k) % DEPTH] ||
                obs_cyc[k] != 3 * (k + 1) + ((k >= 2) ? 5 : 0)) begin
                errors++;
                $display("FAIL wrap_word%0d: data=%h cyc=%0d, required %h cyc %0d", k, obs_data[k],
                         obs_cyc[k], ref_mem[(1022 + k) % DEPTH], 3 * (k + 1) + ((k >= 2) ? 5 : 0));
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != 18 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: count=%0d cyc=%0d busy_after=%b, required 1 18 0",
                     done_cnt, done_cyc, busy_after);
        end
    endtask

    task automatic test_edge_cases();
        run_dump(10, 0, 1, 0, 0, -1, 0, -1);
        vectors++;
        if (timed_out || obs_data.size() != 0 || done_cnt != 1 || done_cyc != 1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL len0: words=%0d done_count=%0d done_cyc=%0d busy_after=%b, required 0 1 1 0",
                     obs_data.size(), done_cnt, done_cyc, busy_after);
        end
        run_dump(20, 2, 1, 0, 0, -1, 0, 2);
        vectors++;
        if (timed_out || obs_data.size() != 2 || done_cyc != 7 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_while_busy: words=%0d done_cyc=%0d, required 2 7",
                     obs_data.size(), done_cyc);
        end
        for (int k = 0; k < 2 && k < obs_data.size(); k++) begin
            vectors++;
            if (obs_data[k] !== ref_mem[20 + k]) begin
                errors++;
                $display("FAIL busy_word%0d: data=%h, required %h", k, obs_data[k], ref_mem[20 + k]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found, g, rvd, rva, saw_done;
        logic [RW-1:0] rd;
        found = 0; saw_done = 0;
        @(posedge clk); #1;
        dump_start = 1'b1; dump_base = 10'd200; dump_len = 11'd5; dump_ready = 1'b0;
        @(posedge clk); #1;
        dump_start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dump_valid) begin
                found = 1;
                reset = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; dump_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (!found || {dump_valid, dump_busy, dump_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_dump: hold_seen=%0d valid/busy/done=%b, required 1 000",
                     found, {dump_valid, dump_busy, dump_done});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dump_done || dump_busy) saw_done = 1;
        end
        vectors++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort_quiet: done/busy seen=1, required 0");
        end
        run_dump(300, 2, 1, 0, 0, -1, 0, -1);
        vectors++;
        if (timed_out || obs_data.size() != 2 || done_cyc != 7 ||
            (obs_data.size() == 2 && (obs_data[0] !== ref_mem[300] || obs_data[1] !== ref_mem[301]))) begin
            errors++;
            $display("FAIL reset_new_dump: words=%0d done_cyc=%0d, required 2 words from 300 done 7",
                     obs_data.size(), done_cyc);
        end
        cpu_read(200, g, rvd, rva, rd);
        vectors++;
        if (rva !== 1'b1 || rd !== ref_mem[200]) begin
            errors++;
            $display("FAIL reset_ram_intact: rvalid=%b data=%h, required 1 %h", rva, rd, ref_mem[200]);
        end
    endtask

    task automatic test_random_dumps();
        bit g, h;
        int base, len, steal_n, steal_addr, bp_word, bp_n, bad;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 4; w++) cpu_write($urandom_range(DEPTH - 1, 0), RW'($urandom), g, h);
            base = $urandom_range(DEPTH - 1, 0);
            len = $urandom_range(8, 1);
            steal_n = $urandom_range(3, 0);
            steal_addr = $urandom_range(DEPTH - 1, 0);
            bp_word = $urandom_range(len - 1, 0);
            bp_n = $urandom_range(4, 0);
            run_dump(base, len, 1, steal_n, steal_addr, bp_word, bp_n, -1);
            bad = 0;
            for (int k = 0; k < len; k++)
                if (k >= obs_data.size() || obs_data[k] !== ref_mem[(base + k) % DEPTH]) bad++;
            for (int k = 0; k < cpu_obs.size(); k++)
                if (cpu_obs[k] !== ref_mem[steal_addr]) bad++;
            vectors++;
            if (timed_out || bad != 0 || obs_data.size() != len || cpu_obs.size() != steal_n || unstable ||
                done_cnt != 1 || done_cyc != 3 * len + 1 + steal_n + bp_n || busy_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_dump%0d: base=%0d len=%0d words=%0d bad=%0d done_cyc=%0d, required done_cyc %0d",
                         it, base, len, obs_data.size(), bad, done_cyc, 3 * len + 1 + steal_n + bp_n);
            end
        end
    endtask

    task automatic test_full_dump();
        int bad;
        run_dump(0, DEPTH, 1, 0, 0, -1, 0, -1);
        bad = 0;
        for (int k = 0; k < DEPTH; k++)
            if (k >= obs_data.size() || obs_data[k] !== ref_mem[k]) bad++;
        vectors++;
        if (timed_out || bad != 0 || obs_data.size() != DEPTH || done_cnt != 1 || done_cyc != 3 * DEPTH + 1) begin
            errors++;
            $display("FAIL full_dump: words=%0d bad=%0d done_cyc=%0d, required %0d 0 %0d",
                     obs_data.size(), bad, done_cyc, DEPTH, 3 * DEPTH + 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dump_start = 1'b0; dump_base = '0; dump_len = '0; dump_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = RW'(i);
            ref_mem[i] = RW'(i);
        end
        test_reset();
        test_plain_dump();
        test_cpu_rw();
        test_contention();
        test_wrap_backpressure();
        test_edge_cases();
        test_reset_mid_dump();
        test_random_dumps();
        test_full_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_data_arbiter.md
MEM_DATA_ARBITER -- requirements
Module: mem_data_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word address width, with depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have CPU ports: i_cpu_req in 1, i_cpu_we in 1, i_cpu_addr in ADDR_WIDTH, i_cpu_wdata in RAM_WIDTH, o_cpu_gnt out 1, o_cpu_rdata out RAM_WIDTH, o_cpu_rvalid out 1.
REQ-006 The block SHALL have dump-request ports: i_dump_start in 1, i_dump_base in ADDR_WIDTH, i_dump_len in ADDR_WIDTH+1 (word count).
REQ-007 The block SHALL have dump-stream ports: o_dump_data out RAM_WIDTH, o_dump_valid out 1, i_dump_ready in 1, o_dump_busy out 1, o_dump_done out 1.
REQ-008 The block SHALL have RAM ports: o_ram_addr out ADDR_WIDTH, o_ram_data out RAM_WIDTH, o_ram_we out 1, i_ram_data in RAM_WIDTH.
REQ-009 The RAM ports SHALL connect to the single-port no-change RAM, which registers its read data one cycle after the address and holds its output on write cycles.

Function
REQ-010 The CPU port SHALL have absolute priority: o_cpu_gnt = i_cpu_req combinationally, every cycle, with no wait states.
REQ-011 When i_cpu_req=1, o_ram_addr SHALL be i_cpu_addr, o_ram_data i_cpu_wdata, and o_ram_we i_cpu_we.
REQ-012 When the CPU request is idle, o_ram_we SHALL be 0 and o_ram_addr SHALL be the dump address (ISSUE state) or hold its last value.
REQ-013 o_cpu_rvalid SHALL be a register set to (i_cpu_req & ~i_cpu_we) of the previous cycle, and o_cpu_rdata SHALL be i_ram_data, giving read latency 1.
REQ-014 The dump FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD, DONE.
REQ-015 In IDLE, i_dump_start=1 SHALL latch base and len, clear the word index, and go to ISSUE, or to DONE if len=0.
REQ-016 i_dump_start SHALL be ignored in every state other than IDLE.
REQ-017 In ISSUE with i_cpu_req=1, the FSM SHALL stay in ISSUE (stolen cycle).
REQ-018 In ISSUE with i_cpu_req=0, the FSM SHALL drive address (base+index) mod 2**ADDR_WIDTH as a read and go to CAPTURE.
REQ-019 In CAPTURE, the block SHALL register i_ram_data into o_dump_data and go to HOLD, regardless of any CPU access in the same cycle.
REQ-020 o_dump_valid SHALL be 1 exactly in HOLD, with o_dump_data stable throughout HOLD.
REQ-021 In HOLD with i_dump_ready=1, the block SHALL increment the index and go to DONE if index+1 = len, else to ISSUE; with i_dump_ready=0 it SHALL stay in HOLD.
REQ-022 In DONE, o_dump_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 o_dump_busy SHALL be 1 in every state except IDLE.
REQ-024 The address SHALL wrap modulo depth (base=1022, len=4 reads 1022, 1023, 0, 1).
REQ-025 len = 2**ADDR_WIDTH SHALL dump the entire memory once.
REQ-026 The uncontended dump rate SHALL be one word per 3 cycles (ISSUE, CAPTURE, HOLD with ready=1).

Reset
REQ-027 While i_reset=1 at a clock edge, the FSM SHALL go to IDLE and the index, base, len, o_dump_data, o_dump_valid, o_dump_done, o_dump_busy and o_cpu_rvalid SHALL clear to 0.
REQ-028 o_cpu_gnt, o_ram_* and o_cpu_rdata SHALL remain combinational during reset, so a CPU request during reset still reaches the RAM.
REQ-029 Reset mid-dump SHALL abort the dump without asserting o_dump_done, leaving RAM contents unaffected.

Verification
REQ-030 Scenario CPU write/read: write 0xBEEF to addr 5, read addr 5 next cycle -> o_cpu_rvalid=1 one cycle after the read with o_cpu_rdata=0xBEEF; gnt same cycle as req.
REQ-031 Scenario plain dump: RAM[i]=i, base=0, len=3, ready=1 -> data 0,1,2 on valid cycles 3 apart, done pulses once, busy low afterwards.
REQ-032 Scenario contention: CPU req held 4 cycles during ISSUE -> dump stalls 4 cycles, no word skipped or duplicated, CPU read data correct.
REQ-033 Scenario wrap plus backpressure: base=1022, len=4, ready low 5 cycles on word 2 -> sequence 1022, 1023, 0, 1 with data held stable while ready is low.
REQ-034 Scenario edge cases: len=0 -> done one cycle after start, no RAM read; start while busy -> ignored.
REQ-035 Scenario reset mid-dump: reset in HOLD -> valid, busy and done all 0 next cycle; a new dump then runs from its own base.
